// File: rtl/led_breath_multi.sv
// rtl/led_breath_multi.sv - multi-channel triangle-wave breathing PWM LED driver
// Define LED_BREATH_GAMMA_EN for a quadratic (perceptual) duty curve instead of linear.
module led_breath_multi #(
    parameter int   NUM_CH   = 4,
    parameter int   PWM_BITS = 8,
    parameter int   PWM_DIV  = 4,
    parameter int   STEP_PWM = 191,
    parameter logic LED_ON   = 1'b1
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode_chase,
    output logic [NUM_CH-1:0] led_out,
    output logic              pwm_wrap,
    output logic              breath_wrap
);
    localparam int DIV_W  = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int STEP_W = (STEP_PWM > 1) ? $clog2(STEP_PWM) : 1;
    localparam int PH_W   = PWM_BITS + 1;

    logic [DIV_W-1:0]    div_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [STEP_W-1:0]   step_cnt;
    logic [PH_W-1:0]     phase;
    logic [PH_W-1:0]     phase_nxt;
    logic                mode_r;
    logic                mode_sel;
    logic                tick;
    logic                pb;
    logic                step_last;
    logic                clr;

    assign clr       = rst || !en;
    assign tick      = (div_cnt == DIV_W'(PWM_DIV - 1));
    assign pb        = tick && (pwm_cnt == '1);
    assign step_last = (step_cnt == STEP_W'(STEP_PWM - 1));
    assign phase_nxt = step_last ? phase + PH_W'(1) : phase;
    // Duties are loaded only on pb, using the mode that the coming period will run in.
    assign mode_sel  = pb ? mode_chase : mode_r;

    always_ff @(posedge sys_clk) begin
        if (clr) begin
            div_cnt     <= '0;
            pwm_cnt     <= '0;
            step_cnt    <= '0;
            phase       <= '0;
            mode_r      <= 1'b0;
            pwm_wrap    <= 1'b0;
            breath_wrap <= 1'b0;
        end else begin
            pwm_wrap    <= pb;
            breath_wrap <= pb && step_last && (phase == '1);
            div_cnt     <= tick ? '0 : div_cnt + DIV_W'(1);
            if (tick) begin
                pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            end
            if (pb) begin
                step_cnt <= step_last ? '0 : step_cnt + STEP_W'(1);
                phase    <= phase_nxt;
                mode_r   <= mode_chase;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam int OFFSET = (i * (1 << PH_W)) / NUM_CH;

        logic [PH_W-1:0]     ph;
        logic [PWM_BITS-1:0] level;
        logic [PWM_BITS-1:0] duty_nxt;
        logic [PWM_BITS-1:0] duty_r;
        logic                led_r;

        always_comb begin
            ph    = phase_nxt + (mode_sel ? PH_W'(OFFSET) : '0);
            level = ph[PH_W-1] ? ~ph[PWM_BITS-1:0] : ph[PWM_BITS-1:0];
        end

`ifdef LED_BREATH_GAMMA_EN
        logic [2*PWM_BITS-1:0] level_w;
        logic [2*PWM_BITS-1:0] square;
        assign level_w  = {{PWM_BITS{1'b0}}, level};
        assign square   = level_w * level_w;
        assign duty_nxt = PWM_BITS'(square >> PWM_BITS);
`else
        assign duty_nxt = level;
`endif

        always_ff @(posedge sys_clk) begin
            if (clr) begin
                duty_r <= '0;
                led_r  <= ~LED_ON;
            end else begin
                if (pb) begin
                    duty_r <= duty_nxt;
                end
                led_r <= (pwm_cnt < duty_r) ? LED_ON : ~LED_ON;
            end
        end

        assign led_out[i] = led_r;
    end
endmodule

// File: tb/tb_led_breath_multi.sv
// tb/tb_led_breath_multi.sv - scoreboard bench for led_breath_multi against a cycle-count reference model
module tb_led_breath_multi;
    logic       sys_clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       mode_chase = 1'b0;
    logic [3:0] led0;
    logic [3:0] led1;
    logic [2:0] led2;
    logic       pw0, pw1, pw2;
    logic       bw0, bw1, bw2;

    always #5 sys_clk = ~sys_clk;

    led_breath_multi #(.NUM_CH(4), .PWM_BITS(3), .PWM_DIV(1), .STEP_PWM(1), .LED_ON(1'b1)) u_dut0 (
        .sys_clk(sys_clk), .rst(rst), .en(en), .mode_chase(mode_chase),
        .led_out(led0), .pwm_wrap(pw0), .breath_wrap(bw0));

    led_breath_multi #(.NUM_CH(4), .PWM_BITS(3), .PWM_DIV(1), .STEP_PWM(1), .LED_ON(1'b0)) u_dut1 (
        .sys_clk(sys_clk), .rst(rst), .en(en), .mode_chase(mode_chase),
        .led_out(led1), .pwm_wrap(pw1), .breath_wrap(bw1));

    led_breath_multi #(.NUM_CH(3), .PWM_BITS(3), .PWM_DIV(3), .STEP_PWM(2), .LED_ON(1'b1)) u_dut2 (
        .sys_clk(sys_clk), .rst(rst), .en(en), .mode_chase(mode_chase),
        .led_out(led2), .pwm_wrap(pw2), .breath_wrap(bw2));

    typedef struct packed {
        logic [2:0][3:0] led;
        logic [2:0]      pw;
        logic [2:0]      bw;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    int c_nch[3]  = '{4, 4, 3};
    int c_bits[3] = '{3, 3, 3};
    int c_div[3]  = '{1, 1, 3};
    int c_step[3] = '{1, 1, 2};
    bit c_on[3]   = '{1'b1, 1'b0, 1'b1};

    // Model state: cycles elapsed since counters were last cleared, plus per-period mode and duties.
    int k_m[3];
    bit mode_m[3];
    int duty_m[3][4];

    function automatic int level_of(input int ph, input int bits);
        int lo;
        lo = ph % (1 << bits);
        if (ph >= (1 << bits)) return (1 << bits) - 1 - lo;
        return lo;
    endfunction

    function automatic int duty_of(input int lvl, input int bits);
`ifdef LED_BREATH_GAMMA_EN
        return (lvl * lvl) >> bits;
`else
        return lvl + 0 * bits;
`endif
    endfunction

    task automatic model_step(input int c, input bit r, input bit e, input bit m,
                              output logic [3:0] led, output logic pw, output logic bw);
        int  p, per, period, pc, ph, off;
        bit  pb;
        p   = 1 << c_bits[c];
        per = c_div[c] * p;
        led = '0;
        if (r || !e) begin
            k_m[c]    = 0;
            mode_m[c] = 1'b0;
            for (int i = 0; i < 4; i++) duty_m[c][i] = 0;
            for (int i = 0; i < c_nch[c]; i++) led[i] = ~c_on[c];
            pw = 1'b0;
            bw = 1'b0;
        end else begin
            pc = (k_m[c] / c_div[c]) % p;
            for (int i = 0; i < c_nch[c]; i++) led[i] = (pc < duty_m[c][i]) ? c_on[c] : ~c_on[c];
            pb     = (k_m[c] % per) == per - 1;
            period = k_m[c] / per;
            pw     = pb;
            bw     = pb && (((period + 1) % (c_step[c] * 2 * p)) == 0);
            k_m[c] = k_m[c] + 1;
            if (pb) begin
                mode_m[c] = m;
                ph = ((period + 1) / c_step[c]) % (2 * p);
                for (int i = 0; i < c_nch[c]; i++) begin
                    off = mode_m[c] ? (i * 2 * p) / c_nch[c] : 0;
                    duty_m[c][i] = duty_of(level_of((ph + off) % (2 * p), c_bits[c]), c_bits[c]);
                end
            end
        end
    endtask

    task automatic cyc(input bit r, input bit e, input bit m);
        exp_t        x;
        logic [3:0]  l;
        logic        p, b;
        @(negedge sys_clk);
        rst        = r;
        en         = e;
        mode_chase = m;
        for (int c = 0; c < 3; c++) begin
            model_step(c, r, e, m, l, p, b);
            x.led[c] = l;
            x.pw[c]  = p;
            x.bw[c]  = b;
        end
        exp_q.push_back(x);
    endtask

    task automatic check(input string name, input int c, input logic [3:0] act, input logic [3:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s dut%0d at %0t: got %b, expected %b", name, c, $time, act, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge sys_clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("led_out", 0, led0, e.led[0]);
                check("led_out", 1, led1, e.led[1]);
                check("led_out", 2, {1'b0, led2}, e.led[2]);
                check("pwm_wrap", 0, {3'b0, pw0}, {3'b0, e.pw[0]});
                check("pwm_wrap", 1, {3'b0, pw1}, {3'b0, e.pw[1]});
                check("pwm_wrap", 2, {3'b0, pw2}, {3'b0, e.pw[2]});
                check("breath_wrap", 0, {3'b0, bw0}, {3'b0, e.bw[0]});
                check("breath_wrap", 1, {3'b0, bw1}, {3'b0, e.bw[1]});
                check("breath_wrap", 2, {3'b0, bw2}, {3'b0, e.bw[2]});
            end
        end
    end

    initial begin : driver
        bit r_v, e_v, m_v;
        repeat (3) cyc(1'b1, 1'b1, 1'b0);
        repeat (400) cyc(1'b0, 1'b1, 1'b0);
        repeat (3) cyc(1'b0, 1'b1, 1'b0);
        repeat (300) cyc(1'b0, 1'b1, 1'b1);
        repeat (5) cyc(1'b0, 1'b1, 1'b0);
        repeat (6) cyc(1'b0, 1'b0, 1'b0);
        repeat (300) cyc(1'b0, 1'b1, 1'b0);
        repeat (99) cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        repeat (250) cyc(1'b0, 1'b1, 1'b0);
        e_v = 1'b1;
        m_v = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            r_v = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 299) == 0) e_v = ~e_v;
            if ($urandom_range(0, 59) == 0) m_v = ~m_v;
            cyc(r_v, e_v, m_v);
        end
        @(posedge sys_clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
